// File: rtl/sc_level_transition_seq_if.sv
// Handshake and pattern bus between a level controller and the transition sequencer.
// master drives the request side, slave is the sequencer.
interface sc_level_transition_seq_if #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int LVL_W = 3
);
  logic                   SC_LevelSeq_clear_InLow;
  logic                   SC_LevelSeq_start_InHigh;
  logic                   SC_LevelSeq_mode_InBUS;
  logic [LVL_W-1:0]       SC_LevelSeq_level_InBUS;
  logic [ROWS*COLS-1:0]   SC_LevelSeq_BACKG_InBUS;
  logic [ROWS*COLS-1:0]   SC_LevelSeq_POINT_InBUS;
  logic [ROWS*COLS-1:0]   SC_LevelSeq_BACKG_OutBUS;
  logic [ROWS*COLS-1:0]   SC_LevelSeq_POINT_OutBUS;
  logic [LVL_W-1:0]       SC_LevelSeq_level_OutBUS;
  logic                   SC_LevelSeq_busy_OutHigh;
  logic                   SC_LevelSeq_done_OutHigh;

  modport master (
    output SC_LevelSeq_clear_InLow, SC_LevelSeq_start_InHigh, SC_LevelSeq_mode_InBUS,
           SC_LevelSeq_level_InBUS, SC_LevelSeq_BACKG_InBUS, SC_LevelSeq_POINT_InBUS,
    input  SC_LevelSeq_BACKG_OutBUS, SC_LevelSeq_POINT_OutBUS, SC_LevelSeq_level_OutBUS,
           SC_LevelSeq_busy_OutHigh, SC_LevelSeq_done_OutHigh
  );

  modport slave (
    input  SC_LevelSeq_clear_InLow, SC_LevelSeq_start_InHigh, SC_LevelSeq_mode_InBUS,
           SC_LevelSeq_level_InBUS, SC_LevelSeq_BACKG_InBUS, SC_LevelSeq_POINT_InBUS,
    output SC_LevelSeq_BACKG_OutBUS, SC_LevelSeq_POINT_OutBUS, SC_LevelSeq_level_OutBUS,
           SC_LevelSeq_busy_OutHigh, SC_LevelSeq_done_OutHigh
  );
endinterface

// File: rtl/sc_level_transition_seq.sv
// Level transition sequencer: instant swap or row wipe/reveal of a two-layer LED matrix.
// Optional point-layer blink after reveal when SC_LEVELSEQ_BLINK_EN is defined.
module sc_level_transition_seq #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int LVL_W       = 3,
  parameter int STEP_CYCLES = 25000000
) (
  input logic                      SC_LevelSeq_CLOCK_50,
  input logic                      SC_LevelSeq_RESET_InHigh,
  sc_level_transition_seq_if.slave seqBus
);
  localparam int W  = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WIPE   = 3'd1,
    REVEAL = 3'd2,
`ifdef SC_LEVELSEQ_BLINK_EN
    BLINK  = 3'd3,
`endif
    DONE   = 3'd4
  } state_t;

  state_t           state_reg;
  logic [W-1:0]     backg_reg, point_reg, backgTgt_reg, pointTgt_reg;
  logic [LVL_W-1:0] level_reg;
  logic             mode_reg, busy_reg, done_reg;
  logic [CW-1:0]    stepCnt_reg;
  logic [RW-1:0]    rowIdx_reg;
`ifdef SC_LEVELSEQ_BLINK_EN
  logic [1:0]       blinkCnt_reg;
`endif

  logic             stepTick;
  logic [ROWS-1:0]  rowHit;
  logic [W-1:0]     backgWipe, pointWipe, backgLoad, pointLoad;

  assign stepTick = (stepCnt_reg == LAST_STEP);

  // Per-row candidates: the selected row is either blanked or taken from the latched target.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign rowHit[gi] = (rowIdx_reg == RW'(gi));
      assign backgWipe[gi*COLS +: COLS] = rowHit[gi] ? '0 : backg_reg[gi*COLS +: COLS];
      assign pointWipe[gi*COLS +: COLS] = rowHit[gi] ? '0 : point_reg[gi*COLS +: COLS];
      assign backgLoad[gi*COLS +: COLS] = rowHit[gi] ? backgTgt_reg[gi*COLS +: COLS]
                                                     : backg_reg[gi*COLS +: COLS];
      assign pointLoad[gi*COLS +: COLS] = rowHit[gi] ? pointTgt_reg[gi*COLS +: COLS]
                                                     : point_reg[gi*COLS +: COLS];
    end
  endgenerate

  always_ff @(posedge SC_LevelSeq_CLOCK_50) begin
    if (SC_LevelSeq_RESET_InHigh) begin
      state_reg    <= IDLE;
      backg_reg    <= '0;
      point_reg    <= '0;
      backgTgt_reg <= '0;
      pointTgt_reg <= '0;
      level_reg    <= '0;
      mode_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      stepCnt_reg  <= '0;
      rowIdx_reg   <= '0;
`ifdef SC_LEVELSEQ_BLINK_EN
      blinkCnt_reg <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (!seqBus.SC_LevelSeq_clear_InLow) begin
        state_reg   <= IDLE;
        busy_reg    <= 1'b0;
        backg_reg   <= '0;
        point_reg   <= '0;
        stepCnt_reg <= '0;
        rowIdx_reg  <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (seqBus.SC_LevelSeq_start_InHigh) begin
              backgTgt_reg <= seqBus.SC_LevelSeq_BACKG_InBUS;
              pointTgt_reg <= seqBus.SC_LevelSeq_POINT_InBUS;
              level_reg    <= seqBus.SC_LevelSeq_level_InBUS;
              mode_reg     <= seqBus.SC_LevelSeq_mode_InBUS;
              stepCnt_reg  <= '0;
              busy_reg     <= 1'b1;
              // Instant mode reuses REVEAL for its single full-frame load.
              state_reg    <= seqBus.SC_LevelSeq_mode_InBUS ? WIPE : REVEAL;
              rowIdx_reg   <= seqBus.SC_LevelSeq_mode_InBUS ? LAST_ROW : '0;
            end
          end
          WIPE: begin
            stepCnt_reg <= stepTick ? '0 : stepCnt_reg + CW'(1);
            if (stepTick) begin
              backg_reg <= backgWipe;
              point_reg <= pointWipe;
              if (rowIdx_reg == '0) state_reg <= REVEAL;
              else                  rowIdx_reg <= rowIdx_reg - RW'(1);
            end
          end
          REVEAL: begin
            if (!mode_reg) begin
              backg_reg <= backgTgt_reg;
              point_reg <= pointTgt_reg;
              state_reg <= DONE;
            end else begin
              stepCnt_reg <= stepTick ? '0 : stepCnt_reg + CW'(1);
              if (stepTick) begin
                backg_reg <= backgLoad;
                point_reg <= pointLoad;
                if (rowIdx_reg == LAST_ROW) begin
`ifdef SC_LEVELSEQ_BLINK_EN
                  state_reg    <= BLINK;
                  blinkCnt_reg <= '0;
`else
                  state_reg    <= DONE;
`endif
                end else begin
                  rowIdx_reg <= rowIdx_reg + RW'(1);
                end
              end
            end
          end
`ifdef SC_LEVELSEQ_BLINK_EN
          BLINK: begin
            stepCnt_reg <= stepTick ? '0 : stepCnt_reg + CW'(1);
            if (stepTick) begin
              // Odd ticks blank the point layer, even ticks restore it.
              point_reg    <= blinkCnt_reg[0] ? pointTgt_reg : '0;
              blinkCnt_reg <= blinkCnt_reg + 2'd1;
              if (blinkCnt_reg == 2'd3) state_reg <= DONE;
            end
          end
`endif
          DONE: begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign seqBus.SC_LevelSeq_BACKG_OutBUS = backg_reg;
  assign seqBus.SC_LevelSeq_POINT_OutBUS = point_reg;
  assign seqBus.SC_LevelSeq_level_OutBUS = level_reg;
  assign seqBus.SC_LevelSeq_busy_OutHigh = busy_reg;
  assign seqBus.SC_LevelSeq_done_OutHigh = done_reg;
endmodule

// File: tb/tb_sc_level_transition_seq.sv
// Directed-plus-random bench for sc_level_transition_seq (ROWS=COLS=8, STEP_CYCLES=4).
// Expected frames come from a tick-count model of wipe/reveal/blink.
module tb_sc_level_transition_seq;
  localparam int ROWS = 8, COLS = 8, LVL_W = 3, STEP = 4;
`ifdef SC_LEVELSEQ_BLINK_EN
  localparam int TICKS = 2 * ROWS + 4;
`else
  localparam int TICKS = 2 * ROWS;
`endif
  localparam int DONE_K = TICKS * STEP + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_level_transition_seq_if #(.ROWS(ROWS), .COLS(COLS), .LVL_W(LVL_W)) bus ();

  sc_level_transition_seq #(.ROWS(ROWS), .COLS(COLS), .LVL_W(LVL_W), .STEP_CYCLES(STEP)) dut (
    .SC_LevelSeq_CLOCK_50    (clk),
    .SC_LevelSeq_RESET_InHigh(rst),
    .seqBus                  (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [63:0] curB, curP;
  logic [2:0]  curL;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame after k edges past acceptance: n ticks done, first ROWS blank rows top-down,
  // next ROWS load rows bottom-up, then blink ticks alternate the point layer 0/T.
  function automatic logic [63:0] model(input logic [63:0] init, input logic [63:0] tgt,
                                        input int k, input bit isPoint);
    int n;
    logic [63:0] r;
    n = k / STEP;
    r = init;
    for (int t = 1; t <= n && t <= ROWS; t++) r[(ROWS - t) * COLS +: COLS] = '0;
    for (int t = ROWS + 1; t <= n && t <= 2 * ROWS; t++)
      r[(t - ROWS - 1) * COLS +: COLS] = tgt[(t - ROWS - 1) * COLS +: COLS];
    if (isPoint && n > 2 * ROWS && n <= TICKS)
      r = ((n - 2 * ROWS) % 2 == 1) ? 64'd0 : tgt;
    return r;
  endfunction

  task automatic randomize_inputs();
    bus.SC_LevelSeq_BACKG_InBUS = {$urandom, $urandom};
    bus.SC_LevelSeq_POINT_InBUS = {$urandom, $urandom};
    bus.SC_LevelSeq_level_InBUS = 3'($urandom_range(0, 7));
    bus.SC_LevelSeq_mode_InBUS  = 1'($urandom_range(0, 1));
  endtask

  task automatic run_instant(input logic [63:0] b, input logic [63:0] p, input logic [2:0] lvl);
    bus.SC_LevelSeq_BACKG_InBUS  = b;
    bus.SC_LevelSeq_POINT_InBUS  = p;
    bus.SC_LevelSeq_level_InBUS  = lvl;
    bus.SC_LevelSeq_mode_InBUS   = 1'b0;
    bus.SC_LevelSeq_start_InHigh = 1'b1;
    step();
    bus.SC_LevelSeq_start_InHigh = 1'b0;
    randomize_inputs();
    chk("inst_level",  64'(bus.SC_LevelSeq_level_OutBUS), 64'(lvl));
    chk("inst_busy0",  64'(bus.SC_LevelSeq_busy_OutHigh), 64'd1);
    chk("inst_hold_b", bus.SC_LevelSeq_BACKG_OutBUS, curB);
    step();
    chk("inst_backg",  bus.SC_LevelSeq_BACKG_OutBUS, b);
    chk("inst_point",  bus.SC_LevelSeq_POINT_OutBUS, p);
    chk("inst_done_early", 64'(bus.SC_LevelSeq_done_OutHigh), 64'd0);
    step();
    chk("inst_done",   64'(bus.SC_LevelSeq_done_OutHigh), 64'd1);
    chk("inst_busy2",  64'(bus.SC_LevelSeq_busy_OutHigh), 64'd0);
    step();
    chk("inst_done_1cyc", 64'(bus.SC_LevelSeq_done_OutHigh), 64'd0);
    chk("inst_hold_p", bus.SC_LevelSeq_POINT_OutBUS, p);
    curB = b; curP = p; curL = lvl;
  endtask

  task automatic run_anim(input logic [63:0] tb_, input logic [63:0] tp, input logic [2:0] lvl,
                          input bit busyStart);
    logic [63:0] initB, initP;
    initB = curB; initP = curP;
    bus.SC_LevelSeq_BACKG_InBUS  = tb_;
    bus.SC_LevelSeq_POINT_InBUS  = tp;
    bus.SC_LevelSeq_level_InBUS  = lvl;
    bus.SC_LevelSeq_mode_InBUS   = 1'b1;
    bus.SC_LevelSeq_start_InHigh = 1'b1;
    step();
    bus.SC_LevelSeq_start_InHigh = 1'b0;
    randomize_inputs();
    for (int k = 0; k <= DONE_K + 1; k++) begin
      chk($sformatf("anim_backg_k%0d", k), bus.SC_LevelSeq_BACKG_OutBUS, model(initB, tb_, k, 1'b0));
      chk($sformatf("anim_point_k%0d", k), bus.SC_LevelSeq_POINT_OutBUS, model(initP, tp, k, 1'b1));
      chk($sformatf("anim_busy_k%0d", k),  64'(bus.SC_LevelSeq_busy_OutHigh), 64'(k < DONE_K));
      chk($sformatf("anim_done_k%0d", k),  64'(bus.SC_LevelSeq_done_OutHigh), 64'(k == DONE_K));
      chk($sformatf("anim_level_k%0d", k), 64'(bus.SC_LevelSeq_level_OutBUS), 64'(lvl));
      bus.SC_LevelSeq_start_InHigh = busyStart && (k == 8);
      if (busyStart && k == 8) begin
        bus.SC_LevelSeq_BACKG_InBUS = ~tb_;
        bus.SC_LevelSeq_POINT_InBUS = ~tp;
        bus.SC_LevelSeq_level_InBUS = ~lvl;
        bus.SC_LevelSeq_mode_InBUS  = 1'b0;
      end
      step();
    end
    bus.SC_LevelSeq_start_InHigh = 1'b0;
    curB = tb_; curP = tp; curL = lvl;
  endtask

  initial begin
    logic [63:0] tB, tP;
    bus.SC_LevelSeq_clear_InLow  = 1'b1;
    bus.SC_LevelSeq_start_InHigh = 1'b1;
    randomize_inputs();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_backg", bus.SC_LevelSeq_BACKG_OutBUS, 64'd0);
      chk("rst_point", bus.SC_LevelSeq_POINT_OutBUS, 64'd0);
      chk("rst_level", 64'(bus.SC_LevelSeq_level_OutBUS), 64'd0);
      chk("rst_busy",  64'(bus.SC_LevelSeq_busy_OutHigh), 64'd0);
      chk("rst_done",  64'(bus.SC_LevelSeq_done_OutHigh), 64'd0);
      randomize_inputs();
    end
    bus.SC_LevelSeq_start_InHigh = 1'b0;
    rst = 1'b0;
    curB = '0; curP = '0; curL = '0;
    step();

    run_instant(64'h003C181818381800, {$urandom, $urandom}, 3'b001);

    run_instant({64{1'b1}}, {64{1'b1}}, 3'd5);
    run_anim({$urandom, $urandom}, {$urandom, $urandom}, 3'd2, 1'b0);

    run_anim({$urandom, $urandom}, {$urandom, $urandom}, 3'd6, 1'b1);

    for (int r = 0; r < 3; r++) begin
      run_instant({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
      run_anim({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)), 1'b0);
    end

    // Clear mid-wipe
    tB = {$urandom, $urandom}; tP = {$urandom, $urandom};
    bus.SC_LevelSeq_BACKG_InBUS  = tB;
    bus.SC_LevelSeq_POINT_InBUS  = tP;
    bus.SC_LevelSeq_mode_InBUS   = 1'b1;
    bus.SC_LevelSeq_start_InHigh = 1'b1;
    step();
    bus.SC_LevelSeq_start_InHigh = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("clr_pre_backg", bus.SC_LevelSeq_BACKG_OutBUS, model(curB, tB, k, 1'b0));
      step();
    end
    bus.SC_LevelSeq_clear_InLow = 1'b0;
    step();
    bus.SC_LevelSeq_clear_InLow = 1'b1;
    chk("clr_backg", bus.SC_LevelSeq_BACKG_OutBUS, 64'd0);
    chk("clr_point", bus.SC_LevelSeq_POINT_OutBUS, 64'd0);
    chk("clr_busy",  64'(bus.SC_LevelSeq_busy_OutHigh), 64'd0);
    for (int k = 0; k < 80; k++) begin
      chk("clr_no_done", 64'(bus.SC_LevelSeq_done_OutHigh), 64'd0);
      step();
    end
    chk("clr_hold_backg", bus.SC_LevelSeq_BACKG_OutBUS, 64'd0);
    curB = '0; curP = '0;

    // Clear overrides a simultaneous start in IDLE
    bus.SC_LevelSeq_clear_InLow  = 1'b0;
    bus.SC_LevelSeq_start_InHigh = 1'b1;
    bus.SC_LevelSeq_mode_InBUS   = 1'b0;
    bus.SC_LevelSeq_BACKG_InBUS  = {64{1'b1}};
    step();
    bus.SC_LevelSeq_clear_InLow  = 1'b1;
    bus.SC_LevelSeq_start_InHigh = 1'b0;
    chk("clrstart_busy", 64'(bus.SC_LevelSeq_busy_OutHigh), 64'd0);
    step();
    chk("clrstart_backg", bus.SC_LevelSeq_BACKG_OutBUS, 64'd0);
    chk("clrstart_done",  64'(bus.SC_LevelSeq_done_OutHigh), 64'd0);

    // Reset mid-reveal
    run_instant({$urandom, $urandom}, {$urandom, $urandom}, 3'd7);
    bus.SC_LevelSeq_BACKG_InBUS  = {$urandom, $urandom};
    bus.SC_LevelSeq_mode_InBUS   = 1'b1;
    bus.SC_LevelSeq_level_InBUS  = 3'd4;
    bus.SC_LevelSeq_start_InHigh = 1'b1;
    step();
    bus.SC_LevelSeq_start_InHigh = 1'b0;
    for (int k = 0; k < 40; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_backg", bus.SC_LevelSeq_BACKG_OutBUS, 64'd0);
    chk("rstmid_point", bus.SC_LevelSeq_POINT_OutBUS, 64'd0);
    chk("rstmid_level", 64'(bus.SC_LevelSeq_level_OutBUS), 64'd0);
    chk("rstmid_busy",  64'(bus.SC_LevelSeq_busy_OutHigh), 64'd0);
    for (int k = 0; k < 60; k++) begin
      chk("rstmid_no_done", 64'(bus.SC_LevelSeq_done_OutHigh), 64'd0);
      step();
    end
    curB = '0; curP = '0; curL = '0;

    run_anim({$urandom, $urandom}, {$urandom, $urandom}, 3'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sc_level_transition_seq.md
SC_LEVEL_TRANSITION_SEQ -- requirements
Module: sc_level_transition_seq

Interface
REQ-001 SHALL have parameter ROWS, default 8, the number of matrix rows.
REQ-002 SHALL have parameter COLS, default 8, the number of matrix columns (bits per row).
REQ-003 SHALL have parameter LVL_W, default 3, the width of the level number.
REQ-004 SHALL have parameter STEP_CYCLES, default 25000000, the clock cycles per animation step (minimum 2).
REQ-005 SHALL have port SC_LevelSeq_CLOCK_50  in  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port SC_LevelSeq_RESET_InHigh  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port SC_LevelSeq_clear_InLow  in  1  synchronous clear, active-low.
REQ-008 SHALL have port SC_LevelSeq_start_InHigh  in  1  request to start a transition.
REQ-009 SHALL have port SC_LevelSeq_mode_InBUS  in  1  transition mode: 0 = instant, 1 = animated row wipe.
REQ-010 SHALL have port SC_LevelSeq_level_InBUS  in  LVL_W  the target level number.
REQ-011 SHALL have port SC_LevelSeq_BACKG_InBUS  in  ROWS*COLS  the target background pattern; row r occupies bits [r*COLS +: COLS].
REQ-012 SHALL have port SC_LevelSeq_POINT_InBUS  in  ROWS*COLS  the target point pattern, with the same row mapping.
REQ-013 SHALL have port SC_LevelSeq_BACKG_OutBUS  out  ROWS*COLS  the displayed background layer, registered.
REQ-014 SHALL have port SC_LevelSeq_POINT_OutBUS  out  ROWS*COLS  the displayed point layer, registered.
REQ-015 SHALL have port SC_LevelSeq_level_OutBUS  out  LVL_W  the latched level number.
REQ-016 SHALL have port SC_LevelSeq_busy_OutHigh  out  1  high in any state other than IDLE.
REQ-017 SHALL have port SC_LevelSeq_done_OutHigh  out  1  a one-cycle pulse when a transition completes.

Function
REQ-018 SHALL implement the states IDLE, WIPE, REVEAL, BLINK (present only with the macro) and DONE.
REQ-019 SHALL accept a start only in IDLE.
- On acceptance: latch both target buses, level_InBUS and mode on that edge.
- start while busy is ignored; the latched data stays unchanged.
REQ-020 SHALL, in instant mode, on the cycle after acceptance:
- load both outputs with the latched targets;
- enter DONE.
REQ-021 SHALL use a step counter for animation:
- the counter restarts at 0 on acceptance;
- it produces a tick when it reaches STEP_CYCLES-1, then wraps to 0.
REQ-022 SHALL run WIPE when the mode is animated.
- The row index starts at ROWS-1.
- Each tick clears that row in both layers and decrements the index.
- The tick that clears row 0 moves to REVEAL with the index at 0.
REQ-023 SHALL run REVEAL as follows.
- Each tick loads row r of both layers from the latched targets and increments r.
- The tick that loads row ROWS-1 exits REVEAL.
- The exit is to BLINK if the macro is defined, otherwise to DONE.
REQ-024 SHALL, in DONE:
- assert done_OutHigh for exactly one cycle;
- return to IDLE on the next edge.
- The outputs hold their last values until the next start.
REQ-025 SHALL give an animated latency, from the acceptance edge to the done pulse, of 2*ROWS*STEP_CYCLES+1 cycles (without the macro).
REQ-026 SHALL update level_OutBUS on the acceptance edge.
REQ-027 SHALL, when clear_InLow is 0 in any state:
- zero both outputs;
- enter IDLE on the next edge, without a done pulse.
- Clear overrides a simultaneous start.
REQ-028 SHALL leave rows not yet processed unchanged during WIPE and REVEAL.

Reset
REQ-029 SHALL give reset priority over clear and start.
REQ-030 SHALL, on reset: state = IDLE; both outputs = 0; level_OutBUS = 0; busy = 0; done = 0; step counter = 0; row index = 0.
REQ-031 SHALL abort any transition in progress on reset mid-operation, without a done pulse.

Configuration
REQ-032 SHALL compile in the BLINK state only when SC_LEVELSEQ_BLINK_EN is defined.
- Defined: BLINK lasts 4 ticks.
- POINT_OutBUS shows zero on blink ticks 1 and 3 and the latched target on ticks 2 and 4; BACKG_OutBUS holds its value.
- BLINK then moves to DONE; the animated latency grows by 4*STEP_CYCLES.
- Undefined: the BLINK state and its logic are absent, and REVEAL goes directly to DONE.
- Instant mode never blinks.

Verification (ROWS=COLS=8, STEP_CYCLES=4)
REQ-033 SHALL cover reset: assert reset for 2 cycles with random inputs -> all outputs 0 and busy=0.
REQ-034 SHALL cover instant mode: start with mode=0, BACKG=64'h003C181818381800, level=3'b001 -> that pattern appears after 1 cycle, done pulses 1 cycle later, level_OutBUS=1.
REQ-035 SHALL cover animated mode: from all-ones outputs, start with mode=1 and a target T -> row 7 is zero after 4 cycles; all zero after 32 cycles; row 0 equals T after 36 cycles; outputs equal T and done pulses at cycle 65.
REQ-036 SHALL cover start while busy: a second start with a different target during WIPE -> it is ignored and the final output is still the first target.
REQ-037 SHALL cover clear mid-WIPE: clear_InLow=0 at cycle 10 -> outputs are 0 and IDLE is entered the next cycle, with no done pulse.
REQ-038 SHALL cover the macro: with SC_LEVELSEQ_BLINK_EN defined, an animated run -> the point layer toggles 0/T/0/T per tick and done pulses at cycle 81.
